// File: rtl/bin_to_bcd_param.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one bit per cycle.
// Optional two's-complement input with a separate sign output, plus a leading-zero blanking mask.
module bin_to_bcd_param #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_en,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  done_tick,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic [DIGITS-1:0]     blank,
  output logic [1:0]            dbg_state
);

  localparam int CW = $clog2(BIN_W + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_ZERO = ~DIGITS'(1);

  function automatic longint pow10(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  generate
    if (BIN_W < 4 || BIN_W > 32) begin : g_bad_width
      $error("bin_to_bcd_param: BIN_W=%0d outside 4..32", BIN_W);
    end
    if (pow10(DIGITS) <= ((longint'(1) << BIN_W) - 1)) begin : g_bad_digits
      $error("bin_to_bcd_param: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
    end
  endgenerate

  // Handshake: start is accepted only on an edge where ready=1; done_tick
  // pulses for one cycle in the same cycle the new bcd/sign/blank appear.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_OP = 2'd1, S_DONE = 2'd2} state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [CW-1:0]      r_cnt;
  logic [BIN_W-1:0]   r_mag;
  logic [BW-1:0]      r_work;
  logic               r_sign_nx;
  logic [BW-1:0]      r_bcd;
  logic               r_sign;
  logic [DIGITS-1:0]  r_blank;

  logic               w_neg;
  logic [BIN_W-1:0]   w_mag_in;
  logic [BW-1:0]      w_adj;
  logic [BW-1:0]      w_work_nx;
  logic [BIN_W-1:0]   w_mag_nx;
  logic               w_unused_msb;
  logic [DIGITS-1:0]  w_blank;
  logic               w_zero_above;

  assign w_neg    = signed_en & bin[BIN_W-1];
  assign w_mag_in = w_neg ? (~bin + BIN_W'(1)) : bin;

  // The top digit's shift-out is always zero given the DIGITS sizing check.
  always_comb begin
    w_adj = r_work;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_work[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
    end
    {w_unused_msb, w_work_nx} = {w_adj, r_mag[BIN_W-1]};
    w_mag_nx = {r_mag[BIN_W-2:0], 1'b0};
  end

  always_comb begin
    w_blank      = '0;
    w_zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_above = w_zero_above && (w_work_nx[4*i +: 4] == 4'd0);
      w_blank[i]   = w_zero_above;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    ready      = 1'b0;
    done_tick  = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_state_nx = S_OP;
      end
      S_OP: begin
        if (r_cnt == CW'(1)) w_state_nx = S_DONE;
      end
      S_DONE: begin
        done_tick  = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_mag     <= '0;
      r_work    <= '0;
      r_sign_nx <= 1'b0;
      r_bcd     <= '0;
      r_sign    <= 1'b0;
      r_blank   <= BLANK_ZERO;
    end else begin
      r_state <= w_state_nx;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mag     <= w_mag_in;
            r_work    <= '0;
            r_cnt     <= CW'(BIN_W);
            r_sign_nx <= w_neg;
          end
        end
        S_OP: begin
          r_work <= w_work_nx;
          r_mag  <= w_mag_nx;
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_bcd   <= w_work_nx;
            r_sign  <= r_sign_nx;
            r_blank <= w_blank;
          end
        end
        default: ;
      endcase
    end
  end

  assign bcd       = r_bcd;
  assign sign      = r_sign;
  assign blank     = r_blank;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bin_to_bcd_param.sv
// Bench for bin_to_bcd_param: default 8-bit instance plus a 16-bit/5-digit instance,
// table vectors and an exhaustive unsigned sweep checked through expected-result queues.
module tb_bin_to_bcd_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, sen8;
  logic [7:0]  bin8;
  logic        ready8, done8, sign8;
  logic [11:0] bcd8;
  logic [2:0]  blank8;
  logic [1:0]  st8;

  logic        start16, sen16;
  logic [15:0] bin16;
  logic        ready16, done16, sign16;
  logic [19:0] bcd16;
  logic [4:0]  blank16;
  logic [1:0]  st16;

  bin_to_bcd_param #(.BIN_W(8), .DIGITS(3)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_en(sen8), .bin(bin8),
    .ready(ready8), .done_tick(done8), .bcd(bcd8), .sign(sign8), .blank(blank8),
    .dbg_state(st8)
  );

  bin_to_bcd_param #(.BIN_W(16), .DIGITS(5)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_en(sen16), .bin(bin16),
    .ready(ready16), .done_tick(done16), .bcd(bcd16), .sign(sign16), .blank(blank16),
    .dbg_state(st16)
  );

  int checks   = 0;
  int failures = 0;

  // Packed expectation: {bcd, sign, blank}
  logic [15:0] exp_q8[$];
  logic [25:0] exp_q16[$];
  logic [11:0] last_bcd8;

  typedef struct {
    logic [7:0]  b;
    logic        s;
    logic [11:0] bcd;
    logic        sg;
    logic [2:0]  blk;
  } vec8_t;

  typedef struct {
    logic [15:0] b;
    logic        s;
    logic [19:0] bcd;
    logic        sg;
    logic [4:0]  blk;
  } vec16_t;

  vec8_t  vecs8[11];
  vec16_t vecs16[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int mag);
    logic [19:0] r = '0;
    int p = 1;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'((mag / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_blank(input int mag);
    logic [4:0] r = '0;
    int p = 10;
    for (int i = 1; i < 5; i++) begin
      r[i] = (mag < p);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic pop8();
    logic [15:0] e;
    if (exp_q8.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_done8: got done_tick expected none");
    end else begin
      e = exp_q8.pop_front();
      chk("bcd8", bcd8, e[15:4]);
      chk("sign8", sign8, e[3]);
      chk("blank8", blank8, e[2:0]);
      last_bcd8 = e[15:4];
    end
  endtask

  task automatic pop16();
    logic [25:0] e;
    if (exp_q16.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_done16: got done_tick expected none");
    end else begin
      e = exp_q16.pop_front();
      chk("bcd16", bcd16, e[25:6]);
      chk("sign16", sign16, e[5]);
      chk("blank16", blank16, e[4:0]);
    end
  endtask

  // Called just after a negedge with the DUT idle; returns just after a negedge.
  task automatic run8(input logic [7:0] b, input logic s, input logic [15:0] exp);
    bit got = 0;
    chk("ready_before8", ready8, 1);
    bin8 = b; sen8 = s; start8 = 1'b1;
    exp_q8.push_back(exp);
    for (int k = 1; k <= 14 && !got; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (k == 2) begin
        chk("busy_ready8", ready8, 0);
        chk("hold_bcd8", bcd8, last_bcd8);
      end
      if (done8) begin
        got = 1;
        chk("latency8", k, 9);
        pop8();
      end
    end
    chk("done_seen8", got, 1);
    if (!got) exp_q8.delete();
    @(negedge clk);
    chk("ready_after8", ready8, 1);
    chk("done_low8", done8, 0);
  endtask

  task automatic run16(input logic [15:0] b, input logic s, input logic [25:0] exp);
    bit got = 0;
    chk("ready_before16", ready16, 1);
    bin16 = b; sen16 = s; start16 = 1'b1;
    exp_q16.push_back(exp);
    for (int k = 1; k <= 22 && !got; k++) begin
      @(negedge clk);
      start16 = 1'b0;
      if (done16) begin
        got = 1;
        chk("latency16", k, 17);
        pop16();
      end
    end
    chk("done_seen16", got, 1);
    if (!got) exp_q16.delete();
    @(negedge clk);
    chk("ready_after16", ready16, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [19:0] rb;
    logic [4:0]  rk;

    vecs8[0]  = '{8'd0,   1'b0, 12'h000, 1'b0, 3'b110};
    vecs8[1]  = '{8'd9,   1'b0, 12'h009, 1'b0, 3'b110};
    vecs8[2]  = '{8'd42,  1'b0, 12'h042, 1'b0, 3'b100};
    vecs8[3]  = '{8'd100, 1'b0, 12'h100, 1'b0, 3'b000};
    vecs8[4]  = '{8'd255, 1'b0, 12'h255, 1'b0, 3'b000};
    vecs8[5]  = '{8'h80,  1'b1, 12'h128, 1'b1, 3'b000};
    vecs8[6]  = '{8'hFF,  1'b1, 12'h001, 1'b1, 3'b110};
    vecs8[7]  = '{8'h7F,  1'b1, 12'h127, 1'b0, 3'b000};
    vecs8[8]  = '{8'h00,  1'b1, 12'h000, 1'b0, 3'b110};
    vecs8[9]  = '{8'h85,  1'b1, 12'h123, 1'b1, 3'b000};
    vecs8[10] = '{8'hF6,  1'b1, 12'h010, 1'b1, 3'b100};

    vecs16[0] = '{16'hFFFF, 1'b0, 20'h65535, 1'b0, 5'b00000};
    vecs16[1] = '{16'h8000, 1'b1, 20'h32768, 1'b1, 5'b00000};
    vecs16[2] = '{16'hFFF6, 1'b1, 20'h00010, 1'b1, 5'b11100};
    vecs16[3] = '{16'd7,    1'b0, 20'h00007, 1'b0, 5'b11110};

    // Clock/reset
    rst = 1'b1; start8 = 1'b0; sen8 = 1'b0; bin8 = '0;
    start16 = 1'b0; sen16 = 1'b0; bin16 = '0;
    last_bcd8 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready8", ready8, 1);
    chk("rst_done8", done8, 0);
    chk("rst_bcd8", bcd8, 12'h000);
    chk("rst_sign8", sign8, 0);
    chk("rst_blank8", blank8, 3'b110);
    chk("rst_blank16", blank16, 5'b11110);
    @(negedge clk);

    // Table vectors
    for (int i = 0; i < 11; i++)
      run8(vecs8[i].b, vecs8[i].s, {vecs8[i].bcd, vecs8[i].sg, vecs8[i].blk});
    for (int i = 0; i < 4; i++)
      run16(vecs16[i].b, vecs16[i].s, {vecs16[i].bcd, vecs16[i].sg, vecs16[i].blk});

    // Exhaustive unsigned sweep, then random signed
    for (int i = 0; i < 256; i++) begin
      rb = ref_bcd(i);
      rk = ref_blank(i);
      run8(8'(i), 1'b0, {rb[11:0], 1'b0, rk[2:0]});
    end
    for (int n = 0; n < 20; n++) begin
      int v, mag;
      logic [7:0] b;
      v = int'($urandom_range(0, 255));
      b = 8'(v);
      mag = b[7] ? 256 - v : v;
      rb = ref_bcd(mag);
      rk = ref_blank(mag);
      run8(b, 1'b1, {rb[11:0], b[7], rk[2:0]});
    end

    // Start during OP is ignored
    bin8 = 8'd200; sen8 = 1'b0; start8 = 1'b1;
    exp_q8.push_back({12'h200, 1'b0, 3'b000});
    ndone = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start8 = (k == 3);
      if (k == 3) bin8 = 8'd55;
      if (k == 2) chk("hs_hold_bcd8", bcd8, last_bcd8);
      if (done8) begin
        ndone++;
        if (ndone == 1) chk("hs_latency8", k, 9);
        pop8();
      end
    end
    chk("hs_one_done8", ndone, 1);
    chk("hs_ready8", ready8, 1);

    // Reset mid-conversion aborts without done_tick
    bin8 = 8'd99; start8 = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (done8) ndone++;
      if (k == 4) rst = 1'b1;
    end
    rst = 1'b0;
    chk("abort_ready8", ready8, 1);
    chk("abort_bcd8", bcd8, 12'h000);
    chk("abort_sign8", sign8, 0);
    chk("abort_blank8", blank8, 3'b110);
    last_bcd8 = 12'h000;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("abort_no_done8", ndone, 0);
    run8(8'd37, 1'b0, {12'h037, 1'b0, 3'b100});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_param.md
Name: bin_to_bcd_param

Overview:
Sequential binary-to-BCD converter (shift-and-add-3 / double dabble), parametrised in input width and BCD digit count. Adds an optional signed (two's complement) input mode with separate sign output, and a leading-zero blanking mask for display drivers. Keeps the start/ready/done_tick handshake of the existing 8-bit converter, so current benches and display paths can drive it unchanged at default parameters.

Parameters:
BIN_W, 8, binary input width; legal range 4..32.
DIGITS, 3, number of BCD output digits; must satisfy 10^DIGITS > 2^BIN_W - 1, otherwise elaboration fails with $error.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request conversion; sampled only when ready=1
signed_en  input  1  1 = treat bin as two's complement; sampled with start
bin  input  BIN_W  binary operand; sampled with start
ready  output  1  high in IDLE only; block accepts start
done_tick  output  1  one-cycle pulse; result outputs updated this cycle
bcd  output  4*DIGITS  result, digit 0 in bits [3:0]; held until next done_tick
sign  output  1  1 = negative result (signed mode only); held with bcd
blank  output  DIGITS  bit i=1 means digit i is a leading zero; bit 0 always 0

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, working registers and iteration counter cleared. Outputs: ready=1, done_tick=0, bcd=0, sign=0, blank = all ones except bit 0. Reset mid-conversion aborts it with no done_tick.
- FSM states: IDLE, OP, DONE.
- IDLE: ready=1. If start=1 at edge E: latch operand and go to OP with counter=BIN_W. Otherwise stay in IDLE.
- Operand latch, unsigned (signed_en=0): magnitude=bin, sign_next=0.
- Operand latch, signed (signed_en=1 and bin[BIN_W-1]=1): magnitude = (~bin + 1) modulo 2^BIN_W, sign_next=1. The most negative value -2^(BIN_W-1) yields magnitude 2^(BIN_W-1), which fits unsigned.
- Operand latch, signed with bin[BIN_W-1]=0: magnitude=bin, sign_next=0.
- OP, one iteration per cycle: every working BCD digit >= 5 gets +3, then the {bcd_work, magnitude} register is shifted left 1. Counter decrements. When the counter reaches 1, the last iteration runs and the state goes to DONE. OP lasts exactly BIN_W cycles, edges E+1..E+BIN_W.
- Iteration arithmetic: each digit adjust is 4-bit. The shift-out of the top digit is discarded; it is provably 0 given the DIGITS constraint.
- DONE is entered at edge E+BIN_W: done_tick=1 for exactly one cycle; bcd, sign and blank registers are loaded on the same edge. Unconditional transition to IDLE at edge E+BIN_W+1, where ready returns to 1.
- Latency: start edge to done_tick rising = BIN_W cycles. Throughput: one conversion per BIN_W+2 cycles, with start held high continuously.
- start while ready=0 (OP or DONE) is ignored entirely. No queueing. bin and signed_en changes during OP have no effect.
- bcd, sign and blank are not disturbed during OP; they show the previous result until the next DONE.
- blank: bit i (i>=1) = 1 iff digits i..DIGITS-1 of the result are all zero. A zero result gives all ones except bit 0.
- sign=1 only with a nonzero magnitude (a negative zero cannot occur).
- Counter width is $clog2(BIN_W+1). No combinational path from inputs to outputs.

Test Plan:
- Reset then idle: rst high 2 cycles -> ready=1, done_tick=0, bcd=12'h000, sign=0, blank=3'b110. Unsigned bin=8'd255 with start at edge E -> done_tick high only in the cycle after E+8, bcd=12'h255, sign=0, blank=3'b000, ready=1 one cycle later.
- Exhaustive unsigned 0..255 against a reference model: 0 -> 12'h000 with blank=3'b110; 9 -> 12'h009 with blank=3'b110; 42 -> 12'h042 with blank=3'b100; 100 -> 12'h100 with blank=3'b000. Zero mismatches.
- Signed mode, default params: 8'h80 -> bcd=12'h128, sign=1; 8'hFF -> bcd=12'h001, sign=1, blank=3'b110; 8'h7F -> bcd=12'h127, sign=0; 8'h00 -> 12'h000, sign=0.
- Handshake: pulse start again at E+3 with a different bin -> ignored, first result delivered unchanged, exactly one done_tick. During OP, bcd still holds the previous result.
- Reset mid-conversion: rst at E+4 -> no done_tick, outputs at reset values, ready=1. The next conversion of 8'd37 yields 12'h037 normally.
- BIN_W=16, DIGITS=5: unsigned 16'hFFFF -> bcd=20'h65535 after 16 cycles. Signed 16'h8000 -> 20'h32768, sign=1. Signed 16'hFFF6 -> 20'h00010, blank=5'b11100. Also elaborate BIN_W=16, DIGITS=4 -> must fail with $error.
